// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Brief    : Non-pipelined issue/writeback stage wrapped around the embertrail
//             ALU, with an internal 8x16 register file.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic [15:0]               iInstr,
    input  logic                      iInstrValid,
    output logic                      oInstrReady,
    output logic [DATA_WIDTH-1:0]     oOperandA,
    output logic [DATA_WIDTH-1:0]     oOperandB,
    output logic [4:0]                oOperation,
    input  logic [DATA_WIDTH-1:0]     iAluResult,
    input  logic [REG_ADDR_WIDTH-1:0] iReadAddr,
    output logic [DATA_WIDTH-1:0]     oReadData,
    output logic                      oDone
);

    localparam int c_NUM_REGS = 2 ** REG_ADDR_WIDTH;

    localparam logic [2:0] c_OPC_MOV  = 3'b000;
    localparam logic [2:0] c_OPC_ADD  = 3'b001;
    localparam logic [2:0] c_OPC_XOR  = 3'b010;
    localparam logic [2:0] c_OPC_OR   = 3'b011;
    localparam logic [2:0] c_OPC_NOT  = 3'b100;
    localparam logic [2:0] c_OPC_AND  = 3'b101;
    localparam logic [2:0] c_OPC_LDI  = 3'b110;
    localparam logic [2:0] c_OPC_RSVD = 3'b111;

    localparam logic [4:0] c_ALU_NONE = 5'b00000;
    localparam logic [4:0] c_ALU_ADD  = 5'b00001;
    localparam logic [4:0] c_ALU_XOR  = 5'b00010;
    localparam logic [4:0] c_ALU_OR   = 5'b00100;
    localparam logic [4:0] c_ALU_NOT  = 5'b01000;
    localparam logic [4:0] c_ALU_AND  = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WRITEBACK = 2'd2
    } state_t;

    state_t                    state_q;
    logic                      ready_q;
    logic                      done_q;
    logic [DATA_WIDTH-1:0]     opa_q;
    logic [DATA_WIDTH-1:0]     opb_q;
    logic [4:0]                op_q;
    logic [REG_ADDR_WIDTH-1:0] dest_q;
    logic                      we_q;
    logic [DATA_WIDTH-1:0]     regs_q [c_NUM_REGS];

    logic [2:0]                w_opcode;
    logic [REG_ADDR_WIDTH-1:0] w_dest;
    logic [REG_ADDR_WIDTH-1:0] w_srca;
    logic [REG_ADDR_WIDTH-1:0] w_srcb;
    logic [DATA_WIDTH-1:0]     opa_d;
    logic [DATA_WIDTH-1:0]     opb_d;
    logic [4:0]                op_d;
    logic                      we_d;
    logic                      w_unused_bits;

    assign w_opcode      = iInstr[15:13];
    assign w_dest        = iInstr[10 +: REG_ADDR_WIDTH];
    assign w_srca        = iInstr[7 +: REG_ADDR_WIDTH];
    assign w_srcb        = iInstr[4 +: REG_ADDR_WIDTH];
    assign w_unused_bits = ^iInstr[3:0];

    // Decode straight from the instruction word; only consumed in IDLE.
    always_comb begin
        opa_d = regs_q[w_srca];
        opb_d = regs_q[w_srcb];
        op_d  = c_ALU_NONE;
        we_d  = 1'b1;
        case (w_opcode)
            c_OPC_MOV:  op_d = c_ALU_NONE;
            c_OPC_ADD:  op_d = c_ALU_ADD;
            c_OPC_XOR:  op_d = c_ALU_XOR;
            c_OPC_OR:   op_d = c_ALU_OR;
            c_OPC_NOT:  op_d = c_ALU_NOT;
            c_OPC_AND:  op_d = c_ALU_AND;
            c_OPC_LDI: begin
                opa_d = '0;
                opb_d = DATA_WIDTH'(iInstr[9:0]);
            end
            c_OPC_RSVD: we_d = 1'b0;
            default:    op_d = c_ALU_NONE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= c_ALU_NONE;
            dest_q  <= '0;
            we_q    <= 1'b0;
            for (int i = 0; i < c_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iInstrValid) begin
                        opa_q   <= opa_d;
                        opb_q   <= opb_d;
                        op_q    <= op_d;
                        dest_q  <= w_dest;
                        we_q    <= we_d;
                        ready_q <= 1'b0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // ALU has captured its inputs at this edge; operands stay put.
                    op_q    <= c_ALU_NONE;
                    done_q  <= 1'b1;
                    state_q <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (we_q) begin
                        regs_q[dest_q] <= iAluResult;
                    end
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oInstrReady = ready_q;
    assign oOperandA   = opa_q;
    assign oOperandB   = opb_q;
    assign oOperation  = op_q;
    assign oDone       = done_q;
    assign oReadData   = regs_q[iReadAddr];

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue/writeback stage directly upstream and downstream of the embertrail ALU.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU operand and one-hot operation inputs, then waits one cycle for the ALU's registered result and writes it back to the destination register.
- Non-pipelined: one instruction in flight, 3 cycles per instruction.

Parameters:
- DATA_WIDTH, 16, operand/result/register width; must equal the ALU width (16).
- REG_ADDR_WIDTH, 3, register address width; 2**REG_ADDR_WIDTH registers (8).

Ports:
- iClock  input  1  clock, all state updates on rising edge.
- iReset  input  1  asynchronous, active-high reset.
- iInstr  input  16  instruction word, sampled on accept.
- iInstrValid  input  1  iInstr is valid.
- oInstrReady  output  1  sequencer can accept an instruction this cycle.
- oOperandA  output  16  to ALU iOperandA (registered).
- oOperandB  output  16  to ALU iOperandB (registered).
- oOperation  output  5  to ALU iOperation, one-hot (registered).
- iAluResult  input  16  from ALU oAluResult (ALU registers internally, 1-cycle latency).
- iReadAddr  input  3  debug register-file read address.
- oReadData  output  16  combinational read of register[iReadAddr].
- oDone  output  1  one-cycle pulse in the WRITEBACK cycle.

Behaviour:
- Instruction format: [15:13] opcode, [12:10] dest, [9:7] srcA, [6:4] srcB, [3:0] ignored.
- Opcode map:
  - 000 MOV: op NONE 00000, ALU passes B.
  - 001 ADD: 00001.
  - 010 XOR: 00010.
  - 011 OR: 00100.
  - 100 NOT: 01000, result is ~A.
  - 101 AND: 10000.
  - 110 LDI: op NONE, oOperandB = {6'b0, iInstr[9:0]}, oOperandA = 0.
  - 111 reserved: behaves as NOP; no write.
- FSM states: IDLE, ISSUE, WRITEBACK.
  - IDLE: oInstrReady = 1. On iInstrValid at an edge, the instruction is accepted. At that same edge:
    - oOperandA/B are loaded from reg[srcA]/reg[srcB] (or the immediate for LDI).
    - oOperation gets its one-hot code (00000 for reserved).
    - dest and a write-enable flag are latched.
    - State goes to ISSUE.
  - ISSUE: oInstrReady = 0. The ALU samples its inputs at the end of this cycle. At that edge oOperation returns to 00000 and state goes to WRITEBACK. Operands are held.
  - WRITEBACK: oInstrReady = 0. iAluResult is valid and oDone = 1. At the edge, reg[dest] <= iAluResult if write-enable is set, then state goes to IDLE.
- Timing: accept at edge E0 → result written at edge E2. Earliest next accept at E3.
- Register reads use values at accept time. A back-to-back dependent instruction sees the previous write, because the write at E2 precedes the accept at E3.
- src == dest is legal: the old value is read and the new value written.
- Arithmetic wraps modulo 2^16 inside the ALU. The sequencer does no arithmetic and there is no carry output.
- iInstrValid while oInstrReady = 0: ignored. The instruction is not consumed, and upstream must hold it.
- Reset (async, any state):
  - State → IDLE.
  - All 8 registers → 0.
  - oOperandA/B → 0, oOperation → 00000, oDone → 0.
  - oInstrReady → 1 after reset deasserts.
  - An instruction in flight is aborted with no writeback, even if reset arrives during WRITEBACK.
- oReadData is combinational from the register file and reflects a write from the cycle after the WRITEBACK edge.

Test Plan:
- Reset, then read all 8 registers → all 0x0000; oInstrReady = 1; oOperation = 00000.
- LDI r1, 0x3FF; then LDI r2, 0x001; then ADD r3 = r1 + r2 → r3 = 0x0400. Check oOperation = 00001 during ISSUE and oDone pulses exactly once per instruction, 2 cycles after each accept.
- LDI r1, 0x3FF; then ADD r1 = r1 + r1 seven times → r1 = 0xFF80 (wrap check via repeated doubling: 0x3FF << 7 mod 2^16). Verify a back-to-back accept is possible on the cycle after oDone.
- LDI r4, 0x0F0; then NOT r5 = ~r4 → 0xFF0F; XOR r6 = r4 ^ r5 → 0xFFFF; AND r7 = r4 & r5 → 0x0000.
- Hold iInstrValid high during ISSUE/WRITEBACK with a different instruction → it is not consumed until IDLE. Opcode 111 accepted → no register changes, oDone still pulses.
- Assert iReset during WRITEBACK of ADD r3 → r3 = 0, state IDLE, no oDone after reset.
